mux12_rr_sched: RTL and testbench



---
 rtl/mux12_pkg.sv | 19 +
 rtl/rr_pick.sv | 38 +++
 rtl/mux12_rr_sched.sv | 107 ++++++++++
 tb/tb_mux12_rr_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux12_pkg.sv
// Shared constants, state type and index helpers for the 12-channel mux scheduler.
package mux12_pkg;

   localparam int unsigned N_CH         = 12;
   localparam int unsigned SEL_W        = 4;
   localparam int unsigned MAX_HOLD_DEF = 8;
   localparam int unsigned CNT_W_DEF    = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Next channel index with wrap from the last channel back to 0.
   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
      return (idx == SEL_W'(N_CH - 1)) ? '0 : idx + SEL_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
   import mux12_pkg::*;
(
   input  logic [N_CH-1:0]  i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_win_c,
   output logic             o_any_c
);

   logic [2*N_CH-1:0] w_dbl;
   logic [N_CH-1:0]   w_rot;
   logic [SEL_W-1:0]  w_off;
   logic              w_found;
   logic [SEL_W:0]    w_sum;

   // Rotate the doubled vector so the pointer lands at bit 0, then find the lowest set bit.
   always_comb begin
      w_dbl   = {i_req, i_req};
      w_rot   = N_CH'(w_dbl >> i_ptr);
      w_off   = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = SEL_W'(k);
         end
      end
      w_sum = (SEL_W+1)'(i_ptr) + (SEL_W+1)'(w_off);
      if (w_sum >= (SEL_W+1)'(N_CH)) begin
         w_sum = w_sum - (SEL_W+1)'(N_CH);
      end
      o_win_c = SEL_W'(w_sum);
   end

   assign o_any_c = |i_req;

endmodule

// File: rtl/mux12_rr_sched.sv
// Round-robin scheduler for a shared 12:1 mux with bounded grant tenure.
module mux12_rr_sched
   import mux12_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [N_CH-1:0]  i_req,
   output logic [SEL_W-1:0] o_sel,
   output logic [N_CH-1:0]  o_grant,
   output logic             o_gnt_valid,
   output logic             o_gnt_start
);

   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   state_t           r_state, w_state_nxt;
   logic [SEL_W-1:0] r_sel, w_sel_nxt;
   logic [N_CH-1:0]  r_grant, w_grant_nxt;
   logic             r_gnt_valid, w_gnt_valid_nxt;
   logic             r_gnt_start, w_gnt_start_nxt;
   logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic [SEL_W-1:0] w_win;
   logic             w_any;
   logic             w_release;

   rr_pick u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_win_c (w_win),
      .o_any_c (w_any)
   );

   assign w_release = !i_req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_grant     <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_start <= 1'b0;
         r_ptr       <= '0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_grant     <= w_grant_nxt;
         r_gnt_valid <= w_gnt_valid_nxt;
         r_gnt_start <= w_gnt_start_nxt;
         r_ptr       <= w_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   // A new grant loads directly from the pick, so back-to-back grants have no idle bubble.
   always_comb begin
      w_state_nxt     = r_state;
      w_sel_nxt       = r_sel;
      w_grant_nxt     = r_grant;
      w_gnt_valid_nxt = r_gnt_valid;
      w_gnt_start_nxt = 1'b0;
      w_ptr_nxt       = r_ptr;
      w_cnt_nxt       = r_cnt;

      unique case (r_state)
         IDLE: begin
            if (i_en && w_any) begin
               w_state_nxt     = GRANT;
               w_sel_nxt       = w_win;
               w_grant_nxt     = N_CH'(1) << w_win;
               w_gnt_valid_nxt = 1'b1;
               w_gnt_start_nxt = 1'b1;
               w_ptr_nxt       = next_idx(w_win);
               w_cnt_nxt       = '0;
            end
         end
         GRANT: begin
            if (!w_release) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else if (i_en && w_any) begin
               w_sel_nxt       = w_win;
               w_grant_nxt     = N_CH'(1) << w_win;
               w_gnt_valid_nxt = 1'b1;
               w_gnt_start_nxt = 1'b1;
               w_ptr_nxt       = next_idx(w_win);
               w_cnt_nxt       = '0;
            end else begin
               w_state_nxt     = IDLE;
               w_grant_nxt     = '0;
               w_gnt_valid_nxt = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_sel       = r_sel;
   assign o_grant     = r_grant;
   assign o_gnt_valid = r_gnt_valid;
   assign o_gnt_start = r_gnt_start;

endmodule

// File: tb/tb_mux12_rr_sched.sv
// Directed and random checks of mux12_rr_sched against an owner/tenure reference model.
module tb_mux12_rr_sched;

   localparam int MAXH = 8;

   logic        clk;
   logic        rst_n;
   logic        i_en;
   logic [11:0] i_req;
   logic [3:0]  o_sel;
   logic [11:0] o_grant;
   logic        o_gnt_valid;
   logic        o_gnt_start;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who owns the mux, how many cycles it has held it, where the next search starts.
   int owner     = -1;
   int held      = 0;
   int next_from = 0;
   int last_sel  = 0;
   bit exp_start = 1'b0;

   mux12_rr_sched #(.MAX_HOLD(MAXH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (i_en),
      .i_req       (i_req),
      .o_sel       (o_sel),
      .o_grant     (o_grant),
      .o_gnt_valid (o_gnt_valid),
      .o_gnt_start (o_gnt_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input int from, input logic [11:0] r);
      for (int k = 0; k < 12; k++) begin
         if (r[(from + k) % 12]) return (from + k) % 12;
      end
      return -1;
   endfunction

   task automatic model_reset();
      owner = -1; held = 0; next_from = 0; last_sel = 0; exp_start = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic [11:0] r);
      if (owner >= 0 && r[owner] && held < MAXH) begin
         held++;
         exp_start = 1'b0;
      end else if (en && r != 12'h000) begin
         owner     = pick(next_from, r);
         held      = 1;
         next_from = (owner + 1) % 12;
         exp_start = 1'b1;
      end else begin
         if (owner >= 0) last_sel = owner;
         owner     = -1;
         exp_start = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [11:0] exp_g;
      int          exp_sel;
      exp_g   = (owner >= 0) ? (12'h001 << owner) : 12'h000;
      exp_sel = (owner >= 0) ? owner : last_sel;
      check({tag, ".sel"},   32'(o_sel),       32'(exp_sel));
      check({tag, ".grant"}, 32'(o_grant),     32'(exp_g));
      check({tag, ".valid"}, 32'(o_gnt_valid), 32'(owner >= 0));
      check({tag, ".start"}, 32'(o_gnt_start), 32'(exp_start));
   endtask

   // One clock: model advances on the edge from the inputs held across it, outputs sampled 1ns later.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step(i_en, i_req);
      #1;
      check_outputs(tag);
   endtask

   task automatic run_until_owner(input int ch, input string tag);
      for (int i = 0; i < 200 && owner != ch; i++) cycle(tag);
      check({tag, ".reach"}, 32'(owner), 32'(ch));
   endtask

   initial begin
      rst_n = 1'b0;
      i_en  = 1'b0;
      i_req = 12'h000;
      #1;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single steady requester: granted next cycle, re-granted every MAXH cycles.
      i_en  = 1'b1;
      i_req = 12'h020;
      for (int i = 0; i < 20; i++) cycle("steady");

      // Everyone requesting: full rotation with no idle cycles.
      i_req = 12'hFFF;
      for (int i = 0; i < 12 * MAXH + 8; i++) cycle("all");

      // Wrap from channel 11 to channel 0 and back.
      run_until_owner(11, "wrap_pre");
      i_req = 12'h801;
      for (int i = 0; i < 2 * MAXH + 4; i++) cycle("wrap");

      // Early release hands over on the same edge.
      i_req = 12'h008;
      run_until_owner(3, "early_pre");
      cycle("early_hold");
      i_req = 12'h080;
      cycle("early_rel");
      for (int i = 0; i < 3; i++) cycle("early_post");

      // Enable dropped mid-tenure: grant completes, then idle; re-enable resumes at 3.
      i_req = 12'h004;
      run_until_owner(2, "en_pre");
      i_req = 12'hFFF;
      i_en  = 1'b0;
      for (int i = 0; i < MAXH + 3; i++) cycle("en_off");
      i_en = 1'b1;
      for (int i = 0; i < 3; i++) cycle("en_on");

      // Asynchronous reset mid-grant of channel 7, then search restarts at 0.
      i_req = 12'h080;
      run_until_owner(7, "rst_pre");
      cycle("rst_hold");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      i_req = 12'hFFF;
      for (int i = 0; i < 4; i++) cycle("rst_after");

      // Random traffic with occasional enable drops.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) i_req = 12'($urandom_range(0, 4095)) & 12'($urandom_range(0, 4095));
         i_en = ($urandom_range(0, 9) != 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
